// File: rtl/vcam_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vcam_pkg
//  Description : Shared constants and per-entry operation priority encoding
//                for the valid-tagged CAM (vcam).
//  Revision    : 1.0 - initial release
// ============================================================================
package vcam_pkg;

    localparam int c_DEFAULT_WIDTH      = 32;
    localparam int c_DEFAULT_ADDR_WIDTH = 5;

    // Operation applied to a single entry in a given cycle, highest priority first.
    typedef enum logic [1:0] {
        FLUSH = 2'd0,
        INVAL = 2'd1,
        WRITE = 2'd2,
        NONE  = 2'd3
    } op_e;

    // Resolve the competing requests that target one entry into a single op.
    function automatic op_e entry_op(input logic flush,
                                     input logic inval_hit,
                                     input logic write_hit);
        if (flush)          return FLUSH;
        else if (inval_hit) return INVAL;
        else if (write_hit) return WRITE;
        return NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vcam_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : vcam_prio_enc
//  Description : Combinational DEPTH-input priority encoder returning the
//                lowest set index and a flag saying any input was set.
//  Revision    : 1.0 - initial release
// ============================================================================
module vcam_prio_enc
    import vcam_pkg::*;
#(
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic [DEPTH-1:0]      i_req,
    output logic [ADDR_WIDTH-1:0] o_index,
    output logic                  o_valid
);

    // Scan from the top down so the lowest set request is the last to win.
    always_comb begin
        o_index = '0;
        o_valid = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_index = ADDR_WIDTH'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vcam.sv
`default_nettype none
// ============================================================================
//  Module      : vcam
//  Description : Valid-tagged content addressable memory. Indexed read,
//                write, invalidate and flush, plus a one-cycle key search
//                reporting the lowest matching valid entry and a running
//                occupancy count. Reads and searches see pre-write state.
//  Options     : define VCAM_MULTI_HIT_EN to add multi_hit_o, flagging
//                searches that match two or more valid entries.
//  Revision    : 1.0 - initial release
// ============================================================================
module vcam
    import vcam_pkg::*;
#(
    parameter int WIDTH      = c_DEFAULT_WIDTH,
    parameter int ADDR_WIDTH = c_DEFAULT_ADDR_WIDTH,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  read_enable_i,
    input  logic [ADDR_WIDTH-1:0] read_index_i,
    input  logic                  write_enable_i,
    input  logic [ADDR_WIDTH-1:0] write_index_i,
    input  logic [WIDTH-1:0]      write_data_i,
    input  logic                  invalidate_enable_i,
    input  logic [ADDR_WIDTH-1:0] invalidate_index_i,
    input  logic                  flush_i,
    input  logic                  search_enable_i,
    input  logic [WIDTH-1:0]      search_data_i,
    output logic                  read_valid_o,
    output logic [WIDTH-1:0]      read_value_o,
    output logic                  search_valid_o,
    output logic [ADDR_WIDTH-1:0] search_index_o,
`ifdef VCAM_MULTI_HIT_EN
    output logic                  multi_hit_o,
`endif
    output logic [ADDR_WIDTH:0]   occupancy_o
);

    localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

    logic [WIDTH-1:0]      r_data [DEPTH];
    logic [DEPTH-1:0]      r_valid;
    logic                  r_read_valid;
    logic [WIDTH-1:0]      r_read_value;
    logic                  r_search_valid;
    logic [ADDR_WIDTH-1:0] r_search_index;
    logic [ADDR_WIDTH:0]   r_occupancy;

    logic                  w_write_ok;
    logic                  w_inval_ok;
    logic                  w_read_hit;
    op_e                   w_op [DEPTH];
    logic [DEPTH-1:0]      w_valid_next;
    logic [DEPTH-1:0]      w_match;
    logic [ADDR_WIDTH-1:0] w_match_index;
    logic                  w_match_any;
    logic [ADDR_WIDTH:0]   w_count;

    // Out-of-range indices are dropped here so they never reach any entry.
    assign w_write_ok = write_enable_i      && ({1'b0, write_index_i}      < c_DEPTH);
    assign w_inval_ok = invalidate_enable_i && ({1'b0, invalidate_index_i} < c_DEPTH);
    assign w_read_hit = read_enable_i && ({1'b0, read_index_i} < c_DEPTH)
                        && r_valid[read_index_i];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign w_op[gi] = entry_op(flush_i,
                                       w_inval_ok && (invalidate_index_i == ADDR_WIDTH'(gi)),
                                       w_write_ok && (write_index_i      == ADDR_WIDTH'(gi)));
            assign w_valid_next[gi] = (w_op[gi] == WRITE) ? 1'b1 :
                                      (w_op[gi] == NONE)  ? r_valid[gi] : 1'b0;
            // Compare against current contents: a same-cycle write is not bypassed.
            assign w_match[gi] = r_valid[gi] && (r_data[gi] == search_data_i);
        end
    endgenerate

    vcam_prio_enc #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_prio_enc (
        .i_req   (w_match),
        .o_index (w_match_index),
        .o_valid (w_match_any)
    );

    // Population count of the valid vector as it will be after this edge.
    always_comb begin
        w_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_count = w_count + {{ADDR_WIDTH{1'b0}}, w_valid_next[i]};
        end
    end

    // Data array carries no reset; stale contents stay hidden behind valid=0.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_op[i] == WRITE) begin
                r_data[i] <= write_data_i;
            end
        end
    end

    // Valid bits and all registered outputs clear asynchronously on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid        <= '0;
            r_read_valid   <= 1'b0;
            r_read_value   <= '0;
            r_search_valid <= 1'b0;
            r_search_index <= '0;
            r_occupancy    <= '0;
        end else begin
            r_valid        <= w_valid_next;
            r_read_valid   <= w_read_hit;
            r_read_value   <= w_read_hit ? r_data[read_index_i] : '0;
            r_search_valid <= search_enable_i && w_match_any;
            r_search_index <= (search_enable_i && w_match_any) ? w_match_index : '0;
            r_occupancy    <= w_count;
        end
    end

`ifdef VCAM_MULTI_HIT_EN
    logic r_multi_hit;
    logic w_multi;

    // Clearing the lowest set bit leaves something only when two or more matched.
    assign w_multi = |(w_match & (w_match - DEPTH'(1)));

    // Registered multi-hit flag, aligned with the search result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_multi_hit <= 1'b0;
        end else begin
            r_multi_hit <= search_enable_i && w_multi;
        end
    end

    assign multi_hit_o = r_multi_hit;
`endif

    assign read_valid_o   = r_read_valid;
    assign read_value_o   = r_read_value;
    assign search_valid_o = r_search_valid;
    assign search_index_o = r_search_index;
    assign occupancy_o    = r_occupancy;

endmodule
`default_nettype wire

// File: tb/tb_vcam.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vcam
//  Description : Directed self-checking bench for vcam (full-depth instance
//                plus a DEPTH=20 instance for out-of-range index handling).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vcam;

    logic        r_clk;
    logic        r_rst;

    // Stimulus and observation for the default (DEPTH=32) instance.
    logic        r_re, r_we, r_ie, r_flush, r_se;
    logic [4:0]  r_ri, r_wi, r_ii;
    logic [31:0] r_wd, r_sd;
    logic        w_rv, w_sv;
    logic [31:0] w_rval;
    logic [4:0]  w_si;
    logic [5:0]  w_occ;
`ifdef VCAM_MULTI_HIT_EN
    logic        w_mh;
`endif

    // Stimulus and observation for the DEPTH=20 instance.
    logic        b_re, b_we, b_ie, b_flush, b_se;
    logic [4:0]  b_ri, b_wi, b_ii;
    logic [31:0] b_wd, b_sd;
    logic        bw_rv, bw_sv;
    logic [31:0] bw_rval;
    logic [4:0]  bw_si;
    logic [5:0]  bw_occ;
`ifdef VCAM_MULTI_HIT_EN
    logic        bw_mh;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    vcam u_dut (
        .clk_i               (r_clk),
        .rst_i               (r_rst),
        .read_enable_i       (r_re),
        .read_index_i        (r_ri),
        .write_enable_i      (r_we),
        .write_index_i       (r_wi),
        .write_data_i        (r_wd),
        .invalidate_enable_i (r_ie),
        .invalidate_index_i  (r_ii),
        .flush_i             (r_flush),
        .search_enable_i     (r_se),
        .search_data_i       (r_sd),
        .read_valid_o        (w_rv),
        .read_value_o        (w_rval),
        .search_valid_o      (w_sv),
        .search_index_o      (w_si),
`ifdef VCAM_MULTI_HIT_EN
        .multi_hit_o         (w_mh),
`endif
        .occupancy_o         (w_occ)
    );

    vcam #(.WIDTH(32), .ADDR_WIDTH(5), .DEPTH(20)) u_dut20 (
        .clk_i               (r_clk),
        .rst_i               (r_rst),
        .read_enable_i       (b_re),
        .read_index_i        (b_ri),
        .write_enable_i      (b_we),
        .write_index_i       (b_wi),
        .write_data_i        (b_wd),
        .invalidate_enable_i (b_ie),
        .invalidate_index_i  (b_ii),
        .flush_i             (b_flush),
        .search_enable_i     (b_se),
        .search_data_i       (b_sd),
        .read_valid_o        (bw_rv),
        .read_value_o        (bw_rval),
        .search_valid_o      (bw_sv),
        .search_index_o      (bw_si),
`ifdef VCAM_MULTI_HIT_EN
        .multi_hit_o         (bw_mh),
`endif
        .occupancy_o         (bw_occ)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic idle();
        r_re = 0; r_we = 0; r_ie = 0; r_flush = 0; r_se = 0;
        r_ri = '0; r_wi = '0; r_ii = '0; r_wd = '0; r_sd = '0;
        b_re = 0; b_we = 0; b_ie = 0; b_flush = 0; b_se = 0;
        b_ri = '0; b_wi = '0; b_ii = '0; b_wd = '0; b_sd = '0;
    endtask

    initial begin
        idle();
        r_rst = 1'b1;
        #3;
        check("reset_read_valid", 64'(w_rv), 64'd0);
        check("reset_search_valid", 64'(w_sv), 64'd0);
        check("reset_occupancy", 64'(w_occ), 64'd0);
        tick();
        tick();
        r_rst = 1'b0;

        // Basic write then search.
        r_we = 1; r_wi = 5'd3; r_wd = 32'hDEADBEEF;
        tick(); idle();
        r_se = 1; r_sd = 32'hDEADBEEF;
        tick(); idle();
        check("srch_deadbeef_valid", 64'(w_sv), 64'd1);
        check("srch_deadbeef_index", 64'(w_si), 64'd3);
        check("occ_after_first_write", 64'(w_occ), 64'd1);
        tick();
        check("srch_disabled_valid", 64'(w_sv), 64'd0);
        check("srch_disabled_index", 64'(w_si), 64'd0);

        // Duplicate key at 7 and 2: lowest index reported.
        r_we = 1; r_wi = 5'd7; r_wd = 32'hA5;
        tick();
        r_wi = 5'd2;
        tick(); idle();
        r_se = 1; r_sd = 32'hA5;
        tick(); idle();
        check("srch_a5_valid", 64'(w_sv), 64'd1);
        check("srch_a5_index", 64'(w_si), 64'd2);
        check("occ_three", 64'(w_occ), 64'd3);
`ifdef VCAM_MULTI_HIT_EN
        check("multi_hit_a5", 64'(w_mh), 64'd1);
        r_se = 1; r_sd = 32'hDEADBEEF;
        tick(); idle();
        check("multi_hit_single", 64'(w_mh), 64'd0);
`endif

        // Write and search same cycle: no bypass.
        r_we = 1; r_wi = 5'd4; r_wd = 32'h55; r_se = 1; r_sd = 32'h55;
        tick(); idle();
        check("srch_same_cycle_valid", 64'(w_sv), 64'd0);
        r_se = 1; r_sd = 32'h55;
        tick(); idle();
        check("srch_next_cycle_valid", 64'(w_sv), 64'd1);
        check("srch_next_cycle_index", 64'(w_si), 64'd4);

        // Reads: hit, disabled, unwritten entry.
        r_re = 1; r_ri = 5'd3;
        tick(); idle();
        check("read3_valid", 64'(w_rv), 64'd1);
        check("read3_value", 64'(w_rval), 64'hDEADBEEF);
        tick();
        check("read_disabled_valid", 64'(w_rv), 64'd0);
        check("read_disabled_value", 64'(w_rval), 64'd0);
        r_re = 1; r_ri = 5'd10;
        tick(); idle();
        check("read_invalid_valid", 64'(w_rv), 64'd0);
        check("read_invalid_value", 64'(w_rval), 64'd0);

        // Overwrite a valid entry: occupancy unchanged.
        r_we = 1; r_wi = 5'd3; r_wd = 32'h12345678;
        tick(); idle();
        check("occ_after_overwrite", 64'(w_occ), 64'd4);
        r_re = 1; r_ri = 5'd3;
        tick(); idle();
        check("read_overwritten", 64'(w_rval), 64'h12345678);

        // Fill every entry.
        for (int i = 0; i < 32; i++) begin
            r_we = 1; r_wi = 5'(i); r_wd = 32'h1000 + 32'(i);
            tick();
        end
        idle();
        check("occ_full", 64'(w_occ), 64'd32);

        // Invalidate beats write on the same index.
        r_ie = 1; r_ii = 5'd5; r_we = 1; r_wi = 5'd5; r_wd = 32'hBAD;
        tick(); idle();
        check("occ_after_inval_write", 64'(w_occ), 64'd31);
        r_re = 1; r_ri = 5'd5;
        tick(); idle();
        check("read_inval_entry", 64'(w_rv), 64'd0);

        // Flush with concurrent search sees pre-flush state.
        r_flush = 1; r_se = 1; r_sd = 32'h1006;
        tick(); idle();
        check("srch_during_flush_valid", 64'(w_sv), 64'd1);
        check("srch_during_flush_index", 64'(w_si), 64'd6);
        check("occ_after_flush", 64'(w_occ), 64'd0);
        r_se = 1; r_sd = 32'h1006;
        tick(); idle();
        check("srch_after_flush", 64'(w_sv), 64'd0);
        r_se = 1; r_sd = 32'h101F;
        tick(); idle();
        check("srch_after_flush_top", 64'(w_sv), 64'd0);

        // Asynchronous reset mid-cycle while outputs are active.
        r_we = 1; r_wi = 5'd9; r_wd = 32'h99;
        tick(); idle();
        r_re = 1; r_ri = 5'd9;
        tick(); idle();
        check("read9_before_reset", 64'(w_rv), 64'd1);
        #2;
        r_rst = 1'b1;
        #1;
        check("async_rst_read_valid", 64'(w_rv), 64'd0);
        check("async_rst_read_value", 64'(w_rval), 64'd0);
        check("async_rst_occupancy", 64'(w_occ), 64'd0);
        tick();
        // Request issued in the cycle reset releases is honoured.
        r_rst = 1'b0;
        r_we = 1; r_wi = 5'd1; r_wd = 32'h11;
        tick(); idle();
        check("occ_write_at_release", 64'(w_occ), 64'd1);
        r_re = 1; r_ri = 5'd9;
        tick(); idle();
        check("read9_after_reset", 64'(w_rv), 64'd0);

        // DEPTH=20 instance: out-of-range indices.
        b_we = 1; b_wi = 5'd2; b_wd = 32'h77;
        tick(); idle();
        check("d20_occ_one", 64'(bw_occ), 64'd1);
        b_we = 1; b_wi = 5'd25; b_wd = 32'h88;
        tick(); idle();
        check("d20_occ_oob_write", 64'(bw_occ), 64'd1);
        b_re = 1; b_ri = 5'd25;
        tick(); idle();
        check("d20_read_oob", 64'(bw_rv), 64'd0);
        b_se = 1; b_sd = 32'h88;
        tick(); idle();
        check("d20_srch_oob_data", 64'(bw_sv), 64'd0);
        b_we = 1; b_wi = 5'd19; b_wd = 32'h1919;
        tick(); idle();
        b_re = 1; b_ri = 5'd19;
        tick(); idle();
        check("d20_read_top_valid", 64'(bw_rv), 64'd1);
        check("d20_read_top_value", 64'(bw_rval), 64'h1919);
        check("d20_occ_two", 64'(bw_occ), 64'd2);
        b_ie = 1; b_ii = 5'd25;
        tick(); idle();
        check("d20_occ_oob_inval", 64'(bw_occ), 64'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vcam.md
VCAM -- requirements
Module: vcam

Interface
REQ-001 Parameter WIDTH, default 32, key/data bit width per entry.
REQ-002 Parameter ADDR_WIDTH, default 5, entry index width.
REQ-003 Parameter DEPTH, default 1<<ADDR_WIDTH, number of entries; legal range 2..(1<<ADDR_WIDTH).
REQ-004 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 read_enable_i  in  1  read request.
REQ-007 read_index_i  in  ADDR_WIDTH  entry to read.
REQ-008 write_enable_i  in  1  write request; sets entry valid.
REQ-009 write_index_i  in  ADDR_WIDTH  entry to write.
REQ-010 write_data_i  in  WIDTH  data to store.
REQ-011 invalidate_enable_i  in  1  clear valid bit of invalidate_index_i.
REQ-012 invalidate_index_i  in  ADDR_WIDTH  entry to invalidate.
REQ-013 flush_i  in  1  clear all valid bits.
REQ-014 search_enable_i  in  1  search request.
REQ-015 search_data_i  in  WIDTH  key to match.
REQ-016 read_valid_o  out  1  registered; read hit on a valid entry.
REQ-017 read_value_o  out  WIDTH  registered read data.
REQ-018 search_valid_o  out  1  registered; at least one valid entry matched.
REQ-019 search_index_o  out  ADDR_WIDTH  registered lowest matching index.
REQ-020 occupancy_o  out  ADDR_WIDTH+1  registered count of valid entries.

Function
REQ-021 Storage: DEPTH entries, each WIDTH data bits plus one valid bit.
REQ-022 Read: latency 1; read_valid_o=1 and read_value_o=data when entry valid, else read_valid_o=0 and read_value_o=0; outputs 0 cycle after read_enable_i=0.
REQ-023 Search: latency 1; entry matches when valid and data==search_data_i; search_index_o = lowest matching index; on no match or search_enable_i=0 both outputs 0 next cycle.
REQ-024 Write: data and valid=1 visible to read/search from the cycle after write_enable_i.
REQ-025 Same-cycle read or search with write to the same entry returns pre-write contents (no bypass).
REQ-026 Index >= DEPTH: read returns read_valid_o=0; write and invalidate ignored.
REQ-027 Priority per entry: flush_i > invalidate > write; write and invalidate to the same index in one cycle leaves entry invalid.
REQ-028 flush_i clears all valid bits in one cycle; data bits unchanged; searches in the same cycle use pre-flush state.
REQ-029 occupancy_o updated each cycle to popcount of next valid vector; range 0..DEPTH, never wraps.
REQ-030 Writing an already-valid entry overwrites data; occupancy unchanged.

Reset
REQ-031 rst_i asserted clears all valid bits and drives every output to 0 immediately, independent of clk_i.
REQ-032 Data array not reset; unreadable until rewritten because valid=0.
REQ-033 Requests in the cycle rst_i deasserts are honoured normally.

Configuration
REQ-034 Macro VCAM_MULTI_HIT_EN defined: extra output multi_hit_o (1 bit, registered, reset 0) =1 when two or more valid entries match a search; lowest index still reported.
REQ-035 VCAM_MULTI_HIT_EN undefined: port and logic absent; all other behaviour identical.

Structure
REQ-036 Package vcam_pkg holds default WIDTH/ADDR_WIDTH constants and an op-priority enum (FLUSH, INVAL, WRITE, NONE).
REQ-037 Sub-module vcam_prio_enc: parametrised DEPTH-input lowest-index priority encoder with valid flag (combinational, instantiated once).

Verification
REQ-038 Reset, write 0xDEADBEEF to index 3, search 0xDEADBEEF next cycle -> search_valid_o=1, search_index_o=3, occupancy_o=1.
REQ-039 Write 0xA5 to indices 7 and 2, search 0xA5 -> search_index_o=2; with VCAM_MULTI_HIT_EN multi_hit_o=1.
REQ-040 Write 0x55 to index 4 and search 0x55 same cycle -> search_valid_o=0; repeat search next cycle -> 1, index 4.
REQ-041 Fill all 32 entries, invalidate 5 and write 5 same cycle -> read index 5 gives read_valid_o=0, occupancy_o=31; flush -> occupancy_o=0, all searches miss.
REQ-042 Assert rst_i mid-cycle with read_valid_o=1 -> all outputs 0 before next edge; read of previously written index after reset -> read_valid_o=0.
REQ-043 DEPTH=20: write index 25 -> ignored, occupancy_o unchanged; read index 25 -> read_valid_o=0.
